// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Provides the default source count, address and data widths, the
// source index assignments, and the buffered request type.
package wb_pkg;

  localparam int NUM_SRC = 3;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 64;

  localparam int SRC_ALU  = 0;
  localparam int SRC_LOAD = 1;
  localparam int SRC_MUL  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for a shared single-ported resource.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset (pointer returns to 0)
//   req    - N request lines, one per requester
//   grant  - one-hot grant (combinational from req and the pointer)
// The search starts at rr_ptr and wraps; after a grant the pointer moves
// to the slot just past the winner, so each requester waits at most N-1
// grants while it is continuously requesting.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;

  always_comb begin
    int idx;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      // rr_ptr < N, so one subtraction is enough to wrap.
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_any && req[idx]) begin
        grant[idx] = 1'b1;
        gnt_idx    = PW'(idx);
        gnt_any    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: shares the single register-file write port among
// the ALU, load and multiply write-back sources.
// Ports:
//   clk, reset    - rising-edge clock, asynchronous active-high reset
//   src_valid     - per-source request present
//   src_ready     - per-source accept (depends on internal state only)
//   src_addr      - packed destination registers, source i at [i*ADDR_W +: ADDR_W]
//   src_data      - packed write values, same packing
//   rf_we/rf_addr/rf_data - registered register-file write
//   pending_mask  - bit r set while any buffered request targets register r
// Each source owns a one-entry holding buffer. A round-robin arbiter picks
// one full buffer per cycle; the winner is registered onto the rf_* port.
module writeback_arbiter #(
  parameter int NUM_SRC = wb_pkg::NUM_SRC,
  parameter int ADDR_W  = wb_pkg::ADDR_W,
  parameter int DATA_W  = wb_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_data,
  output logic [2**ADDR_W-1:0]      pending_mask
);

  logic [NUM_SRC-1:0] vld_p0;
  logic [NUM_SRC-1:0] grant_p0;
  logic [NUM_SRC-1:0] accept;
  logic [ADDR_W-1:0]  addr_p0 [NUM_SRC];
  logic [DATA_W-1:0]  data_p0 [NUM_SRC];
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // ---- stage p0: per-source holding buffers ----

  // A buffer being drained this edge can take a new request at the same
  // edge, which is what lets a lone source sustain one write per cycle.
  assign src_ready = ~vld_p0 | grant_p0;
  assign accept    = src_valid & src_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= '0;
    end else begin
      vld_p0 <= accept | (vld_p0 & ~grant_p0);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (accept[i]) begin
        addr_p0[i] <= src_addr[i*ADDR_W +: ADDR_W];
        data_p0[i] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  rr_arbiter #(
    .N (NUM_SRC)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (vld_p0),
    .grant (grant_p0)
  );

  // Grant is one-hot, so an OR of the masked buffers is the selected entry.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_p0[i]) begin
        sel_addr = sel_addr | addr_p0[i];
        sel_data = sel_data | data_p0[i];
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (vld_p0[i]) pending_mask[addr_p0[i]] = 1'b1;
    end
  end

  // ---- stage p1: registered register-file write port ----

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else if (|grant_p0) begin
      rf_we   <= 1'b1;
      rf_addr <= sel_addr;
      rf_data <= sel_data;
    end else begin
      rf_we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter. Requests are queued per
// source and driven on the falling edge; the expected writes are queued
// in the order the round-robin must produce them and compared as rf_we
// pulses appear.
module tb_writeback_arbiter;
  import wb_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_SRC-1:0]        src_valid = '0;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*ADDR_W-1:0] src_addr = '0;
  logic [NUM_SRC*DATA_W-1:0] src_data = '0;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_addr;
  logic [DATA_W-1:0]         rf_data;
  logic [2**ADDR_W-1:0]      pending_mask;

  int n_cmp = 0;
  int n_err = 0;

  wb_req_t            send_q [NUM_SRC][$];
  wb_req_t            exp_q [$];
  logic [NUM_SRC-1:0] acc = '0;
  int                 wr_per_addr [2**ADDR_W];

  writeback_arbiter #(
    .NUM_SRC (NUM_SRC),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_addr     (src_addr),
    .src_data     (src_data),
    .rf_we        (rf_we),
    .rf_addr      (rf_addr),
    .rf_data      (rf_data),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input int s, input int a, input logic [63:0] d);
    wb_req_t r;
    r.addr = ADDR_W'(a);
    r.data = d;
    send_q[s].push_back(r);
    exp_q.push_back(r);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Source drivers: present the head of each queue, retire it once accepted.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (acc[i] && send_q[i].size() > 0) void'(send_q[i].pop_front());
        if (!reset && send_q[i].size() > 0) begin
          src_valid[i]                  = 1'b1;
          src_addr[i*ADDR_W +: ADDR_W]  = send_q[i][0].addr;
          src_data[i*DATA_W +: DATA_W]  = send_q[i][0].data;
        end else begin
          src_valid[i] = 1'b0;
        end
      end
      acc = src_valid & src_ready;
    end
  end

  // Write monitor: every rf_we pulse must match the next expected write.
  initial begin
    wb_req_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rf_we === 1'b1) begin
        wr_per_addr[rf_addr]++;
        if (exp_q.size() == 0) begin
          check("spurious_we", {63'b0, rf_we}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {60'b0, rf_addr}, {60'b0, e.addr});
          check("wr_data", rf_data, e.data);
        end
      end
    end
  end

  initial begin
    logic [7:0] we_vec;
    logic       rdy_all;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_rf_we",   {63'b0, rf_we}, 64'h0);
    check("reset_rf_addr", {60'b0, rf_addr}, 64'h0);
    check("reset_rf_data", rf_data, 64'h0);
    check("reset_pending", {48'b0, pending_mask}, 64'h0);
    check("reset_ready",   {61'b0, src_ready}, 64'h7);
    @(negedge clk);
    reset = 1'b0;
    tick(1);

    // Contention from a fresh pointer: reg2, reg3, reg4 on consecutive cycles.
    send(SRC_ALU, 2, 64'h20);
    send(SRC_LOAD, 3, 64'h30);
    send(SRC_MUL, 4, 64'h40);
    tick(1);
    check("contend_pending", {48'b0, pending_mask}, 64'h001C);
    check("contend_no_we_yet", {63'b0, rf_we}, 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("contend_we", {63'b0, rf_we}, 64'h1);
    end
    tick(1);
    check("contend_we_done", {63'b0, rf_we}, 64'h0);

    // Single ALU stream: back-to-back accepts, five consecutive writes.
    for (int k = 1; k <= 5; k++) send(SRC_ALU, k, 64'hA0 + 64'(k));
    we_vec  = '0;
    rdy_all = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      we_vec[k] = rf_we;
      rdy_all   = rdy_all & src_ready[SRC_ALU];
    end
    check("single_we_pattern", {56'b0, we_vec}, 64'h3E);
    check("single_ready_high", {63'b0, rdy_all}, 64'h1);

    // Wrap: load granted first (pointer -> 2), then MUL, then ALU.
    send(SRC_LOAD, 5, 64'h51);
    tick(1);
    send(SRC_MUL, 9, 64'h92);
    send(SRC_ALU, 6, 64'h60);
    tick(1);
    check("wrap_load_first", {60'b0, rf_addr}, 64'h5);
    tick(1);
    check("wrap_mul_next", {60'b0, rf_addr}, 64'h9);
    tick(1);
    check("wrap_alu_last", {60'b0, rf_addr}, 64'h6);
    tick(2);

    // Pending mask: ALU ahead of load (reg7) and MUL (reg12).
    send(SRC_MUL, 13, 64'hD2);
    tick(4);
    send(SRC_ALU, 3, 64'h33);
    send(SRC_LOAD, 7, 64'h77);
    send(SRC_MUL, 12, 64'hCC);
    tick(1);
    check("pend_all3", {48'b0, pending_mask}, 64'h1088);
    tick(1);
    check("pend_ld_mul", {48'b0, pending_mask}, 64'h1080);
    tick(1);
    check("pend_mul", {48'b0, pending_mask}, 64'h1000);
    tick(1);
    check("pend_empty", {48'b0, pending_mask}, 64'h0);
    tick(2);

    // Fairness: all sources continuously valid for 30 writes.
    foreach (wr_per_addr[a]) wr_per_addr[a] = 0;
    for (int k = 0; k < 10; k++)
      for (int s = 0; s < NUM_SRC; s++)
        send(s, s + 1, 64'hF000 + 64'(s * 16 + k));
    tick(35);
    check("fair_src0", 64'(wr_per_addr[1]), 64'd10);
    check("fair_src1", 64'(wr_per_addr[2]), 64'd10);
    check("fair_src2", 64'(wr_per_addr[3]), 64'd10);
    check("fair_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-traffic with all buffers full and a write on the port.
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < NUM_SRC; s++)
        send(s, 8 + s, 64'hB00 + 64'(s * 16 + k));
    tick(2);
    check("pre_reset_we", {63'b0, rf_we}, 64'h1);
    check("pre_reset_pending", {48'b0, pending_mask}, 64'h0700);
    reset = 1'b1;
    for (int s = 0; s < NUM_SRC; s++) send_q[s].delete();
    exp_q.delete();
    #1;
    check("midrst_rf_we",   {63'b0, rf_we}, 64'h0);
    check("midrst_rf_addr", {60'b0, rf_addr}, 64'h0);
    check("midrst_rf_data", rf_data, 64'h0);
    check("midrst_pending", {48'b0, pending_mask}, 64'h0);
    check("midrst_ready",   {61'b0, src_ready}, 64'h7);
    tick(2);
    @(negedge clk);
    reset = 1'b0;
    tick(1);

    // Pointer must be back at 0: order reg2, reg3, reg4 again.
    send(SRC_ALU, 2, 64'h21);
    send(SRC_LOAD, 3, 64'h31);
    send(SRC_MUL, 4, 64'h41);
    tick(2);
    check("postrst_first", {60'b0, rf_addr}, 64'h2);
    tick(4);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
